// File: rtl/pes_pump_pkg.sv
// Shared types and constants for the pump driver.
// The dry-run option is selected with PES_PUMP_DRYRUN_EN in the files that use this package.
package pes_pump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_COOL  = 2'd2,
    ST_FAULT = 2'd3
  } pump_state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_DRY     = 2'b10;

endpackage

// File: rtl/pes_pump_cnt.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
// Reset is asynchronous, active-low.
module pes_pump_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pes_pump_driver.sv
// Pump power driver: minimum/maximum run time, cool-down and latched faults.
// Define PES_PUMP_DRYRUN_EN to add the flow_ok input and the dry-run fault.
module pes_pump_driver
  import pes_pump_pkg::*;
#(
  parameter int MIN_ON_CYC  = 4,
  parameter int MAX_ON_CYC  = 1000,
  parameter int MIN_OFF_CYC = 8,
  parameter int CNT_W       = 16
`ifdef PES_PUMP_DRYRUN_EN
  ,
  parameter int DRY_CYC     = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       water_pump,
  input  logic       fault_clr,
`ifdef PES_PUMP_DRYRUN_EN
  input  logic       flow_ok,
`endif
  output logic       pump_on,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [CNT_W-1:0] MIN_ON_LAST  = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_ON_LAST  = CNT_W'(MAX_ON_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_OFF_LAST = CNT_W'(MIN_OFF_CYC - 1);

  pump_state_t      r_state;
  pump_state_t      w_state_next;
  logic [1:0]       r_fault_code;
  logic [1:0]       w_fault_code_next;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_dry_hit;

  // The state counter restarts from zero on every state change.
  assign w_cnt_clr = (w_state_next != r_state);
  assign w_cnt_en  = (r_state == ST_RUN) || (r_state == ST_COOL);

  pes_pump_cnt #(.CNT_W(CNT_W)) u_state_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_cnt)
  );

`ifdef PES_PUMP_DRYRUN_EN
  localparam logic [CNT_W-1:0] DRY_LAST = CNT_W'(DRY_CYC - 1);

  logic [CNT_W-1:0] w_dry_cnt;
  logic             w_dry_clr;
  logic             w_dry_en;

  // Counts consecutive no-flow RUN cycles; the current cycle completes the streak.
  assign w_dry_clr = (r_state != ST_RUN) || flow_ok;
  assign w_dry_en  = (r_state == ST_RUN) && !flow_ok;
  assign w_dry_hit = w_dry_en && (w_dry_cnt == DRY_LAST);

  pes_pump_cnt #(.CNT_W(CNT_W)) u_dry_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_dry_clr),
    .i_en  (w_dry_en),
    .o_cnt (w_dry_cnt)
  );
`else
  assign w_dry_hit = 1'b0;
`endif

  always_comb begin
    w_state_next      = r_state;
    w_fault_code_next = r_fault_code;
    case (r_state)
      ST_IDLE: begin
        if (water_pump) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        // A request drop after the minimum run outranks both faults.
        if (!water_pump && (w_cnt >= MIN_ON_LAST)) begin
          w_state_next = ST_COOL;
        end else if (w_dry_hit) begin
          w_state_next      = ST_FAULT;
          w_fault_code_next = FC_DRY;
        end else if (water_pump && (w_cnt == MAX_ON_LAST)) begin
          w_state_next      = ST_FAULT;
          w_fault_code_next = FC_TIMEOUT;
        end
      end
      ST_COOL: begin
        if (w_cnt == MIN_OFF_LAST) w_state_next = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr && !water_pump) begin
          w_state_next      = ST_COOL;
          w_fault_code_next = FC_NONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_fault_code <= FC_NONE;
    end else begin
      r_state      <= w_state_next;
      r_fault_code <= w_fault_code_next;
    end
  end

  assign pump_on    = (r_state == ST_RUN);
  assign fault      = (r_state == ST_FAULT);
  assign fault_code = r_fault_code;

endmodule

// File: tb/tb_pes_pump_driver.sv
// Self-checking bench for pes_pump_driver: directed scenarios plus random requests
// compared cycle by cycle against a behavioural model.
module tb_pes_pump_driver;

  localparam int MIN_ON  = 4;
  localparam int MAX_ON  = 10;
  localparam int MIN_OFF = 3;
  localparam int DRY_CYC = 5;
`ifdef PES_PUMP_DRYRUN_EN
  localparam bit DRY_EN = 1'b1;
`else
  localparam bit DRY_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       water_pump;
  logic       fault_clr;
  logic       flow_ok;
  logic       pump_on;
  logic       fault;
  logic [1:0] fault_code;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: on-time / cool-down bookkeeping rather than a state register
  bit m_on;
  bit m_fault;
  int m_code;
  int m_on_cycles;
  int m_cool_left;
  int m_dry;

  // run-length trackers
  int cur_len  = 0;
  int last_len = 0;
  int low_len  = 0;
  int last_low = 0;

  pes_pump_driver #(
    .MIN_ON_CYC  (MIN_ON),
    .MAX_ON_CYC  (MAX_ON),
    .MIN_OFF_CYC (MIN_OFF),
    .CNT_W       (16)
`ifdef PES_PUMP_DRYRUN_EN
    ,
    .DRY_CYC     (DRY_CYC)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .water_pump (water_pump),
    .fault_clr  (fault_clr),
`ifdef PES_PUMP_DRYRUN_EN
    .flow_ok    (flow_ok),
`endif
    .pump_on    (pump_on),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on        = 1'b0;
    m_fault     = 1'b0;
    m_code      = 0;
    m_on_cycles = 0;
    m_cool_left = 0;
    m_dry       = 0;
  endtask

  task automatic model_step(input bit wp, input bit clr, input bit fl);
    if (!rst) begin
      model_reset();
    end else if (m_fault) begin
      if (clr && !wp) begin
        m_fault     = 1'b0;
        m_code      = 0;
        m_cool_left = MIN_OFF;
      end
    end else if (m_on) begin
      m_on_cycles++;
      if (!fl) m_dry++;
      else     m_dry = 0;
      if (!wp && m_on_cycles >= MIN_ON) begin
        m_on        = 1'b0;
        m_cool_left = MIN_OFF;
      end else if (DRY_EN && m_dry >= DRY_CYC) begin
        m_on    = 1'b0;
        m_fault = 1'b1;
        m_code  = 2;
      end else if (wp && m_on_cycles >= MAX_ON) begin
        m_on    = 1'b0;
        m_fault = 1'b1;
        m_code  = 1;
      end
    end else if (m_cool_left > 0) begin
      m_cool_left--;
    end else if (wp) begin
      m_on        = 1'b1;
      m_on_cycles = 0;
      m_dry       = 0;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare against the model.
  task automatic cycle(input bit wp, input bit clr, input bit fl);
    water_pump = wp;
    fault_clr  = clr;
    flow_ok    = fl;
    @(posedge clk);
    model_step(wp, clr, fl);
    #1;
    check_val("pump_on", int'(pump_on), int'(m_on));
    check_val("fault", int'(fault), int'(m_fault));
    check_val("fault_code", int'(fault_code), m_code);
    if (pump_on) begin
      if (cur_len == 0) last_low = low_len;
      cur_len++;
    end else begin
      if (cur_len > 0) begin
        last_len = cur_len;
        $display("run ended: on_cycles=%0d fault=%0d code=%0d t=%0t", cur_len, fault, fault_code, $time);
        cur_len = 0;
        low_len = 0;
      end
      low_len++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst        = 1'b0;
    water_pump = 1'b1;
    fault_clr  = 1'b0;
    flow_ok    = 1'b1;
    model_reset();

    // reset held with the request high
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    check_val("reset_pump_on", int'(pump_on), 0);
    check_val("reset_fault_code", int'(fault_code), 0);
    rst = 1'b1;
    cur_len = 0;
    low_len = 0;
    idle_cycles(2);

    // short pulse: minimum run then cool-down plus idle sample
    cycle(1'b1, 1'b0, 1'b1);
    idle_cycles(4);
    check_val("short_pulse_len", last_len, MIN_ON);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1);
    check_val("short_pulse_off", last_low, MIN_OFF + 1);
    idle_cycles(10);

    // normal run of 7 cycles, next request raised during cool-down
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check_val("normal_len", last_len, 7);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1);
    check_val("cool_wait", last_low, MIN_OFF + 1);
    idle_cycles(10);

    // timeout fault, ignored clear while requested, then proper clear
    for (int i = 0; i < MAX_ON + 1; i++) cycle(1'b1, 1'b0, 1'b1);
    check_val("timeout_len", last_len, MAX_ON);
    check_val("timeout_fault", int'(fault), 1);
    check_val("timeout_code", int'(fault_code), 1);
    cycle(1'b1, 1'b1, 1'b1);
    check_val("clr_ignored", int'(fault), 1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check_val("clr_fault", int'(fault), 0);
    check_val("clr_code", int'(fault_code), 0);
    idle_cycles(5);

    // request drop coincides with the last allowed run cycle
    for (int i = 0; i < MAX_ON; i++) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check_val("simul_len", last_len, MAX_ON);
    check_val("simul_no_fault", int'(fault), 0);
    idle_cycles(5);

    // asynchronous reset mid-run
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    check_val("pre_reset_on", int'(pump_on), 1);
    #2;
    rst = 1'b0;
    #1;
    check_val("async_reset_on", int'(pump_on), 0);
    model_reset();
    cur_len = 0;
    low_len = 0;
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(2);

`ifdef PES_PUMP_DRYRUN_EN
    // no flow from run entry
    for (int i = 0; i < DRY_CYC + 1; i++) cycle(1'b1, 1'b0, 1'b0);
    check_val("dry_len", last_len, DRY_CYC);
    check_val("dry_code", int'(fault_code), 2);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    idle_cycles(5);
    // intermittent flow keeps the streak below the limit
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, (i % 4) == 3);
    cycle(1'b0, 1'b0, 1'b1);
    check_val("flow_toggle_len", last_len, 9);
    check_val("flow_toggle_fault", int'(fault), 0);
    idle_cycles(5);
`endif

    // randomized request bursts
    for (int b = 0; b < 150; b++) begin
      bit lvl;
      int hold;
      lvl  = ($urandom % 3) != 0;
      hold = int'($urandom_range(1, 14));
      for (int i = 0; i < hold; i++) begin
        cycle(lvl, ($urandom % 6) == 0, ($urandom % 8) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
